// File: rtl/ram_pkg.sv
// Shared definitions for the dual-port synchronous RAM and its clear-sweep controller.
package ram_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset sweep controller: walks every address once, then parks in RUN until the next reset.
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  output logic          busy,
  output logic [AW-1:0] clr_addr,
  output logic          clr_we
);

  localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};
  localparam logic [AW-1:0] ONE       = {{(AW-1){1'b0}}, 1'b1};

  state_t        state_r;
  logic [AW-1:0] cnt_r;
  logic          busy_r;

  // Sweep FSM; leaves CLEAR on the same edge that writes the last address.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_CLEAR;
      cnt_r   <= {AW{1'b0}};
      busy_r  <= 1'b1;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          if (cnt_r == LAST_ADDR) begin
            state_r <= ST_RUN;
            busy_r  <= 1'b0;
          end else begin
            cnt_r <= cnt_r + ONE;
          end
        end
        ST_RUN: begin
          state_r <= ST_RUN;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_CLEAR;
          cnt_r   <= {AW{1'b0}};
          busy_r  <= 1'b1;
        end
      endcase
    end
  end

  assign busy     = busy_r;
  assign clr_we   = busy_r;
  assign clr_addr = cnt_r;

endmodule

// File: rtl/ram_sync_dp.sv
// Dual-port synchronous RAM: port A read/write, port B read-only (video scan) with write-first bypass.
// Define RAM_SYNC_DP_CLEAR_EN to fill the array with INIT after every reset before accepting accesses.
module ram_sync_dp
  import ram_pkg::*;
#(
  parameter int            AW   = 8,
  parameter int            DW   = 4,
  parameter logic [DW-1:0] INIT = {DW{1'b0}}
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_en,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_din,
  output logic [DW-1:0] a_dout,
  input  logic          b_en,
  input  logic [AW-1:0] b_addr,
  output logic [DW-1:0] b_dout,
  output logic          ready
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem_r [DEPTH];
  logic [DW-1:0] a_dout_r;
  logic [DW-1:0] b_dout_r;
  logic          ready_s;
  logic          clr_we_s;
  logic [AW-1:0] clr_addr_s;

`ifdef RAM_SYNC_DP_CLEAR_EN
  logic busy_s;

  ram_clear_seq #(.AW(AW)) u_clear_seq (
    .clk      (clk),
    .reset    (reset),
    .busy     (busy_s),
    .clr_addr (clr_addr_s),
    .clr_we   (clr_we_s)
  );

  assign ready_s = ~busy_s;
`else
  logic ready_r;

  // Without the sweep the array is usable on the first edge after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_r <= 1'b0;
    end else begin
      ready_r <= 1'b1;
    end
  end

  assign ready_s    = ready_r;
  assign clr_we_s   = 1'b0;
  assign clr_addr_s = {AW{1'b0}};
`endif

  logic          a_wr_s;
  logic          a_rd_s;
  logic          b_rd_s;
  logic          wr_en_s;
  logic [AW-1:0] wr_addr_s;
  logic [DW-1:0] wr_data_s;

  // Request qualification and the single array write port (sweep has priority; reset blocks all writes).
  always_comb begin
    a_wr_s    = ready_s & a_en & a_we & ~reset;
    a_rd_s    = ready_s & a_en & ~a_we & ~reset;
    b_rd_s    = ready_s & b_en & ~reset;
    wr_en_s   = 1'b0;
    wr_addr_s = a_addr;
    wr_data_s = a_din;
    if (clr_we_s && !reset) begin
      wr_en_s   = 1'b1;
      wr_addr_s = clr_addr_s;
      wr_data_s = INIT;
    end else if (a_wr_s) begin
      wr_en_s   = 1'b1;
      wr_addr_s = a_addr;
      wr_data_s = a_din;
    end else begin
      wr_en_s   = 1'b0;
    end
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_addr_s] <= wr_data_s;
    end
  end

  // Registered read ports; each holds its value on cycles without a read.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_dout_r <= {DW{1'b0}};
      b_dout_r <= {DW{1'b0}};
    end else begin
      if (a_rd_s) begin
        a_dout_r <= mem_r[a_addr];
      end
      if (b_rd_s) begin
        b_dout_r <= (a_wr_s && (a_addr == b_addr)) ? a_din : mem_r[b_addr];
      end
    end
  end

  assign a_dout = a_dout_r;
  assign b_dout = b_dout_r;
  assign ready  = ready_s;

endmodule
